// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding data-memory access with lane steering,
// sign extension, fault detection and a bounded wait for the memory acknowledge.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_mask_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  fault_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] FAULT_OK    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN = 2'b01;
  localparam logic [1:0] FAULT_F3    = 2'b10;
  localparam logic [1:0] FAULT_TMO   = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_mask_q, mem_mask_d;
  logic             done_q, done_d;
  logic [1:0]       fault_q, fault_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             illegal_c;
  logic             misalign_c;
  logic [3:0]       st_mask_c;
  logic [31:0]      st_data_c;
  logic [31:0]      shifted_c;
  logic [31:0]      ld_data_c;

  // Request decode on the live inputs, used only in the accepting IDLE cycle.
  always_comb begin
    if (we_i) illegal_c = (funct3_i != 3'b000) && (funct3_i != 3'b001) && (funct3_i != 3'b010);
    else      illegal_c = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
    misalign_c = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    case (funct3_i[1:0])
      2'b00: begin
        st_mask_c = 4'b0001 << addr_i[1:0];
        st_data_c = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        st_mask_c = 4'b0011 << {addr_i[1], 1'b0};
        st_data_c = {2{wdata_i[15:0]}};
      end
      default: begin
        st_mask_c = 4'b1111;
        st_data_c = wdata_i;
      end
    endcase
  end

  // Load lane extraction from the acknowledged read word.
  always_comb begin
    shifted_c = mem_rdata_i >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  ld_data_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b100:  ld_data_c = {24'h000000, shifted_c[7:0]};
      3'b001:  ld_data_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
      3'b101:  ld_data_c = {16'h0000, shifted_c[15:0]};
      default: ld_data_c = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    done_d      = 1'b0;
    fault_d     = FAULT_OK;
    rdata_d     = 32'h0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          we_d        = we_i;
          funct3_d    = funct3_i;
          addr_d      = addr_i;
          mem_wdata_d = st_data_c;
          mem_mask_d  = st_mask_c;
          cnt_d       = '0;
          if (illegal_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = FAULT_F3;
          end else if (misalign_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            fault_d = FAULT_ALIGN;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = we_q ? 32'h0 : ld_data_c;
        end else if (cnt_q == TMO_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          fault_d = FAULT_TMO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_mask_q  <= 4'b0000;
      done_q      <= 1'b0;
      fault_q     <= FAULT_OK;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_wdata_o = mem_wdata_q;
  assign mem_mask_o  = mem_mask_q;
  assign stall_o     = ((state_q == IDLE) && valid_i) || (state_q == REQ);
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected completions to a
// scoreboard, an independent monitor checks every done_o pulse against it.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_mask_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic [1:0]  fault_o;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .we_i(we_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_mask_o(mem_mask_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o),
    .done_o(done_o), .rdata_o(rdata_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  fault;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completion must match the oldest expectation, including its cycle.
  always @(negedge clk) begin
    if (done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done_o), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_fault", 32'(fault_o), 32'(e.fault));
        chk("done_rdata", rdata_o, e.rdata);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One transaction; called just after a rising edge with the DUT idle.
  // exp_reqs = 0 means a faulted request that must never reach memory.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_n, input int exp_reqs,
                         input logic [31:0] mrd, input logic [1:0] ef,
                         input logic [31:0] erd, input int lat, input logic chk_st,
                         input logic [3:0] e_mask, input logic [31:0] e_wdata);
    exp_t e;
    int   n;
    valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    @(negedge clk);
    chk("stall_idle_valid", 32'(stall_o), 32'd1);
    e.fault = ef; e.rdata = erd; e.cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    n = 0;
    while (mem_req_o && n < 300) begin
      n++;
      if (n == ack_n) begin
        mem_ack_i = 1'b1; mem_rdata_i = mrd;
      end
      @(negedge clk);
      chk("stall_req", 32'(stall_o), 32'd1);
      chk("mem_addr", mem_addr_o, {a[31:2], 2'b00});
      chk("mem_we", 32'(mem_we_o), 32'(we));
      if (chk_st) begin
        chk("mem_mask", 32'(mem_mask_o), 32'(e_mask));
        chk("mem_wdata", mem_wdata_o, e_wdata);
      end
      @(posedge clk); #1;
      mem_ack_i = 1'b0; mem_rdata_i = 32'hDEAD_0000;
    end
    chk("req_cycles", 32'(n), 32'(exp_reqs));
    @(negedge clk);
    chk("stall_done", 32'(stall_o), 32'd0);
    chk("req_done", 32'(mem_req_o), 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(mem_req_o), 32'd0);
    chk({tag, "_we"},    32'(mem_we_o), 32'd0);
    chk({tag, "_addr"},  mem_addr_o, 32'd0);
    chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
    chk({tag, "_mask"},  32'(mem_mask_o), 32'd0);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_done"},  32'(done_o), 32'd0);
    chk({tag, "_rdata"}, rdata_o, 32'd0);
    chk({tag, "_fault"}, 32'(fault_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0;
    wdata_i = 32'h0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // we, f3, addr, wdata, ack_n, reqs, mem_rdata, fault, rdata, latency, chk_st, mask, wdata
    run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 1, 1, 32'h80AA_BBCC, 2'b00, 32'hFFFF_FF80, 2, 1'b0, 4'h0, 32'h0);
    run_txn(1'b0, 3'b100, 32'h0000_1003, 32'h0, 1, 1, 32'h80AA_BBCC, 2'b00, 32'h0000_0080, 2, 1'b0, 4'h0, 32'h0);
    run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 4, 4, 32'hFFFF_FFFF, 2'b00, 32'h0, 5, 1'b1, 4'b1100, 32'hABCD_ABCD);
    run_txn(1'b0, 3'b010, 32'h0000_0006, 32'h0, 0, 0, 32'h0, 2'b01, 32'h0, 1, 1'b0, 4'h0, 32'h0);
    run_txn(1'b0, 3'b011, 32'h0000_0000, 32'h0, 0, 0, 32'h0, 2'b10, 32'h0, 1, 1'b0, 4'h0, 32'h0);
    run_txn(1'b0, 3'b111, 32'h0000_0003, 32'h0, 0, 0, 32'h0, 2'b10, 32'h0, 1, 1'b0, 4'h0, 32'h0);
    run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, -1, 4, 32'h0, 2'b11, 32'h0, 5, 1'b0, 4'h0, 32'h0);
    run_txn(1'b0, 3'b001, 32'h0000_0402, 32'h0, 2, 2, 32'h8001_7FFF, 2'b00, 32'hFFFF_8001, 3, 1'b0, 4'h0, 32'h0);
    run_txn(1'b0, 3'b101, 32'h0000_0402, 32'h0, 2, 2, 32'h8001_7FFF, 2'b00, 32'h0000_8001, 3, 1'b0, 4'h0, 32'h0);
    run_txn(1'b0, 3'b000, 32'h0000_0402, 32'h0, 1, 1, 32'h8001_7FFF, 2'b00, 32'h0000_0001, 2, 1'b0, 4'h0, 32'h0);
    run_txn(1'b0, 3'b010, 32'h0000_0404, 32'h0, 1, 1, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 2, 1'b0, 4'h0, 32'h0);
    run_txn(1'b1, 3'b000, 32'h0000_0501, 32'h0000_00A5, 1, 1, 32'h5555_5555, 2'b00, 32'h0, 2, 1'b1, 4'b0010, 32'hA5A5_A5A5);
    run_txn(1'b1, 3'b010, 32'h0000_0600, 32'hCAFE_F00D, 3, 3, 32'h5555_5555, 2'b00, 32'h0, 4, 1'b1, 4'b1111, 32'hCAFE_F00D);
    run_txn(1'b1, 3'b100, 32'h0000_0000, 32'h0, 0, 0, 32'h0, 2'b10, 32'h0, 1, 1'b0, 4'h0, 32'h0);
    run_txn(1'b1, 3'b001, 32'h0000_0001, 32'h0, 0, 0, 32'h0, 2'b01, 32'h0, 1, 1'b0, 4'h0, 32'h0);

    // Reset in the second REQ cycle together with an ack: request abandoned silently.
    valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0040; wdata_i = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_txn_req1", 32'(mem_req_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_in_req");
    @(posedge clk); #1;
    run_txn(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 1, 1, 32'h0, 2'b00, 32'h0, 2, 1'b1, 4'b1111, 32'h1122_3344);

    repeat (8) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
